// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared constants and address decode for the memory/IO responder.
//   IO_SEL       value of mem_a[17:16] that selects the IO window
//   IO_UART_OFS  IO offset (mem_a[2:0]) of the UART data register
//   IO_CNT_OFS   IO offset of the cycle counter / stop register
package mem_io_pkg;

  localparam logic [1:0] IO_SEL      = 2'b11;
  localparam logic [2:0] IO_UART_OFS = 3'd0;
  localparam logic [2:0] IO_CNT_OFS  = 3'd4;

  // Only bits [17:16] take part in the decode, so only they are passed in.
  function automatic logic is_io(input logic [1:0] sel);
    return sel == IO_SEL;
  endfunction

endpackage

// File: rtl/byte_fifo.sv
// byte_fifo: byte-wide circular queue of 2**AW entries.
//   clk_in, rst_in  clock, synchronous active-high reset (empties the queue)
//   push, wdata     enqueue request and byte; dropped when full unless a pop
//                   happens in the same cycle
//   pop             dequeue request; ignored when empty
//   rdata           head of queue (valid while !empty)
//   full, empty     occupancy flags
//   count           current occupancy
//   count_next      occupancy after this cycle's accepted push/pop
module byte_fifo #(
  parameter int AW = 4
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          push,
  input  logic [7:0]    wdata,
  input  logic          pop,
  output logic [7:0]    rdata,
  output logic          full,
  output logic          empty,
  output logic [AW:0]   count,
  output logic [AW:0]   count_next
);

  localparam logic [AW:0] DEPTH = (AW+1)'(1 << AW);

  logic [7:0]    mem [2**AW];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty = (count == '0);
  assign full  = (count == DEPTH);
  assign rdata = mem[rd_ptr];

  // A pop frees the slot the same-cycle push needs, so a full queue still
  // accepts a push when it is also being drained.
  always_comb begin
    pop_ok     = pop && !empty;
    push_ok    = push && (!full || pop_ok);
    count_next = count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
    end
  end

  // Storage is not reset; only the pointers define what is valid.
  always_ff @(posedge clk_in) begin
    if (push_ok) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: memory-side responder for the CPU byte bus.
// Serves a 2**RAM_AW byte RAM plus an IO window at mem_a[17:16]==2'b11 holding
// the UART TX/RX queues, a free-running cycle counter and the program-stop flag.
//   clk_in, rst_in       clock, synchronous active-high reset
//   mem_a, mem_wr        CPU address and write strobe
//   mem_wdata            CPU write byte
//   mem_rdata            read byte, registered one cycle after the address
//   io_buffer_full       TX queue has <= FULL_MARGIN free slots
//   tx_data, tx_valid    head of TX queue to the UART transmitter
//   tx_ready             transmitter takes tx_data this cycle
//   rx_data, rx_valid    byte from the UART receiver, queued when valid
//   program_stop         sticky, set by a write to offset 4
//   tx_overflow          sticky, a TX byte was dropped on a full queue
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_AW      = 17,
  parameter int TXQ_AW      = 4,
  parameter int RXQ_AW      = 4,
  parameter int FULL_MARGIN = 2
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] mem_a,
  input  logic        mem_wr,
  input  logic [7:0]  mem_wdata,
  output logic [7:0]  mem_rdata,
  output logic        io_buffer_full,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        program_stop,
  output logic        tx_overflow
);

  localparam logic [TXQ_AW:0] TX_FULL_AT = (TXQ_AW+1)'((1 << TXQ_AW) - FULL_MARGIN);

  logic [7:0]        ram [2**RAM_AW];
  logic [RAM_AW-1:0] ram_addr;
  logic              io_sel;
  logic [2:0]        io_ofs;
  logic              ram_we;

  logic [31:0]       cycle_cnt;
  logic [31:8]       snap;

  logic              tx_push;
  logic [7:0]        tx_wdata;
  logic              tx_pop;
  logic              tx_full;
  logic              tx_empty;
  logic [TXQ_AW:0]   tx_count;
  logic [TXQ_AW:0]   tx_count_next;

  logic              rx_pop;
  logic [7:0]        rx_head;
  logic              rx_full;
  logic              rx_empty;
  logic [RXQ_AW:0]   rx_count;
  logic [RXQ_AW:0]   rx_count_next;

  logic              stop_set;
  logic              snap_en;
  logic [7:0]        rd_next;

  logic              unused_sigs;
  assign unused_sigs = ^{mem_a[31:18], rx_full, rx_count, rx_count_next, tx_count};

  assign io_sel   = is_io(mem_a[17:16]);
  assign io_ofs   = mem_a[2:0];
  assign ram_addr = mem_a[RAM_AW-1:0];
  assign ram_we   = mem_wr && !io_sel;

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign rx_pop   = !mem_wr && io_sel && (io_ofs == IO_UART_OFS);
  assign snap_en  = !mem_wr && io_sel && (io_ofs == IO_CNT_OFS);
  assign stop_set = mem_wr && io_sel && (io_ofs == IO_CNT_OFS);

  // Zero bytes written to the UART register are ignored; the stop register
  // always pushes a zero so the host sees an end-of-output marker.
  always_comb begin
    tx_push  = 1'b0;
    tx_wdata = 8'h00;
    if (mem_wr && io_sel) begin
      if (io_ofs == IO_UART_OFS) begin
        tx_push  = (mem_wdata != 8'h00);
        tx_wdata = mem_wdata;
      end else if (io_ofs == IO_CNT_OFS) begin
        tx_push  = 1'b1;
        tx_wdata = 8'h00;
      end
    end
  end

  // Offset 4 returns the live counter low byte; 5..7 come from the snapshot
  // taken at that read so a multi-byte read sees one coherent value.
  always_comb begin
    rd_next = 8'h00;
    if (io_sel) begin
      case (io_ofs)
        3'd0:    rd_next = rx_empty ? 8'h00 : rx_head;
        3'd4:    rd_next = cycle_cnt[7:0];
        3'd5:    rd_next = snap[15:8];
        3'd6:    rd_next = snap[23:16];
        3'd7:    rd_next = snap[31:24];
        default: rd_next = 8'h00;
      endcase
    end else begin
      rd_next = ram[ram_addr];
    end
  end

  always_ff @(posedge clk_in) begin
    if (ram_we) ram[ram_addr] <= mem_wdata;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      mem_rdata      <= 8'h00;
      cycle_cnt      <= 32'd0;
      snap           <= '0;
      program_stop   <= 1'b0;
      tx_overflow    <= 1'b0;
      io_buffer_full <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + 32'd1;
      if (!mem_wr) mem_rdata <= rd_next;
      if (snap_en) snap <= cycle_cnt[31:8];
      if (stop_set) program_stop <= 1'b1;
      if (tx_push && tx_full && !tx_pop) tx_overflow <= 1'b1;
      io_buffer_full <= (tx_count_next >= TX_FULL_AT);
    end
  end

  byte_fifo #(.AW(TXQ_AW)) u_tx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (tx_push),
    .wdata      (tx_wdata),
    .pop        (tx_pop),
    .rdata      (tx_data),
    .full       (tx_full),
    .empty      (tx_empty),
    .count      (tx_count),
    .count_next (tx_count_next)
  );

  byte_fifo #(.AW(RXQ_AW)) u_rx_fifo (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .push       (rx_valid),
    .wdata      (rx_data),
    .pop        (rx_pop),
    .rdata      (rx_head),
    .full       (rx_full),
    .empty      (rx_empty),
    .count      (rx_count),
    .count_next (rx_count_next)
  );

endmodule

// File: tb/tb_mem_io_responder.sv
module tb_mem_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        io_buffer_full;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        program_stop;
  logic        tx_overflow;

  int assertions = 0;
  int failures   = 0;

  always #5 clk_in = ~clk_in;

  mem_io_responder dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .mem_wdata      (mem_wdata),
    .mem_rdata      (mem_rdata),
    .io_buffer_full (io_buffer_full),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .program_stop   (program_stop),
    .tx_overflow    (tx_overflow)
  );

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    mem_a  = 32'h0;
    mem_wr = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    rst_in = 1'b1;
    tick();
    tick();
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    rst_in = 1'b1;
    tick();
    assertions++;
    if ({mem_rdata, io_buffer_full, tx_valid, program_stop, tx_overflow} !== 12'h000) begin
      failures++;
      $display("FAIL reset_outputs: got rdata=%h ibf=%b txv=%b stop=%b ovf=%b required all 0",
               mem_rdata, io_buffer_full, tx_valid, program_stop, tx_overflow);
    end
    rst_in = 1'b0;
  endtask

  task automatic test_ram();
    mem_a = 32'h10; mem_wr = 1'b1; mem_wdata = 8'hA5;
    tick();
    mem_wr = 1'b0;
    tick();
    assertions++;
    if (mem_rdata !== 8'hA5) begin
      failures++; $display("FAIL ram_raw: got %h required a5", mem_rdata);
    end
    mem_a = 32'h20010; mem_wr = 1'b1; mem_wdata = 8'h3C;
    tick();
    assertions++;
    if (mem_rdata !== 8'hA5) begin
      failures++; $display("FAIL rdata_hold_on_write: got %h required a5", mem_rdata);
    end
    mem_a = 32'h10; mem_wr = 1'b0;
    tick();
    assertions++;
    if (mem_rdata !== 8'h3C) begin
      failures++; $display("FAIL ram_alias: got %h required 3c", mem_rdata);
    end
    mem_a = 32'h1FFFF; mem_wr = 1'b1; mem_wdata = 8'h77;
    tick();
    mem_wr = 1'b0;
    tick();
    assertions++;
    if (mem_rdata !== 8'h77) begin
      failures++; $display("FAIL ram_top_addr: got %h required 77", mem_rdata);
    end
  endtask

  task automatic test_tx_basic();
    do_reset();
    tx_ready = 1'b0;
    mem_a = 32'h30000; mem_wr = 1'b1;
    mem_wdata = 8'h41; tick();
    mem_wdata = 8'h00; tick();
    mem_wdata = 8'h42; tick();
    idle();
    assertions++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h41) begin
      failures++; $display("FAIL tx_first: got valid=%b data=%h required 1/41", tx_valid, tx_data);
    end
    tx_ready = 1'b1;
    tick();
    assertions++;
    if (tx_valid !== 1'b1 || tx_data !== 8'h42) begin
      failures++; $display("FAIL tx_second: got valid=%b data=%h required 1/42", tx_valid, tx_data);
    end
    tick();
    assertions++;
    if (tx_valid !== 1'b0) begin
      failures++; $display("FAIL tx_zero_ignored: got valid=%b required 0 after two pops", tx_valid);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_full();
    int pops;
    do_reset();
    tx_ready = 1'b0;
    mem_a = 32'h30000; mem_wr = 1'b1; mem_wdata = 8'h5A;
    for (int i = 1; i <= 17; i++) begin
      tick();
      if (i == 13) begin
        assertions++;
        if (io_buffer_full !== 1'b0) begin
          failures++; $display("FAIL ibf_at_13: got %b required 0", io_buffer_full);
        end
      end
      if (i == 14) begin
        assertions++;
        if (io_buffer_full !== 1'b1) begin
          failures++; $display("FAIL ibf_at_14: got %b required 1", io_buffer_full);
        end
      end
      if (i == 16) begin
        assertions++;
        if (tx_overflow !== 1'b0) begin
          failures++; $display("FAIL ovf_at_16: got %b required 0", tx_overflow);
        end
      end
    end
    assertions++;
    if (tx_overflow !== 1'b1) begin
      failures++; $display("FAIL ovf_at_17: got %b required 1", tx_overflow);
    end
    idle();
    tx_ready = 1'b1;
    pops = 0;
    for (int i = 0; i < 24 && tx_valid; i++) begin
      tick();
      pops++;
    end
    assertions++;
    if (pops != 16 || io_buffer_full !== 1'b0) begin
      failures++; $display("FAIL tx_drain: got pops=%0d ibf=%b required 16/0", pops, io_buffer_full);
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_counter();
    do_reset();
    repeat (20) tick();
    mem_wr = 1'b0;
    mem_a = 32'h30004; tick();
    assertions++;
    if (mem_rdata !== 8'd20) begin
      failures++; $display("FAIL cnt_byte0: got %0d required 20", mem_rdata);
    end
    mem_a = 32'h30005; tick();
    assertions++;
    if (mem_rdata !== 8'd0) begin
      failures++; $display("FAIL cnt_byte1: got %h required 00", mem_rdata);
    end
    mem_a = 32'h30006; tick();
    mem_a = 32'h30007; tick();
    assertions++;
    if (mem_rdata !== 8'd0) begin
      failures++; $display("FAIL cnt_byte3: got %h required 00", mem_rdata);
    end
    mem_a = 32'h30004; tick();
    assertions++;
    if (mem_rdata !== 8'd24) begin
      failures++; $display("FAIL cnt_reread: got %0d required 24", mem_rdata);
    end
    mem_a = 32'h30001; tick();
    assertions++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL io_other_ofs: got %h required 00", mem_rdata);
    end
    idle();
  endtask

  task automatic test_rx();
    do_reset();
    rx_data = 8'h37; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    mem_a = 32'h30000;
    tick();
    assertions++;
    if (mem_rdata !== 8'h37) begin
      failures++; $display("FAIL rx_pop: got %h required 37", mem_rdata);
    end
    tick();
    assertions++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL rx_empty: got %h required 00", mem_rdata);
    end
    rx_data = 8'h99; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    assertions++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL rx_push_pop_empty: got %h required 00", mem_rdata);
    end
    idle();
    tick();
    mem_a = 32'h30000;
    tick();
    assertions++;
    if (mem_rdata !== 8'h99) begin
      failures++; $display("FAIL rx_queued: got %h required 99", mem_rdata);
    end
    idle();
  endtask

  task automatic test_stop();
    do_reset();
    tx_ready = 1'b0;
    mem_a = 32'h30002; mem_wr = 1'b1; mem_wdata = 8'h55;
    tick();
    assertions++;
    if (tx_valid !== 1'b0 || program_stop !== 1'b0) begin
      failures++; $display("FAIL io_write_ignored: got txv=%b stop=%b required 0/0", tx_valid, program_stop);
    end
    mem_a = 32'h30004; mem_wdata = 8'hEE;
    tick();
    idle();
    assertions++;
    if (program_stop !== 1'b1 || tx_valid !== 1'b1 || tx_data !== 8'h00) begin
      failures++; $display("FAIL stop_marker: got stop=%b txv=%b data=%h required 1/1/00",
                           program_stop, tx_valid, tx_data);
    end
  endtask

  task automatic test_mid_reset();
    mem_a = 32'h30000; mem_wr = 1'b1; mem_wdata = 8'h61;
    tick();
    idle();
    rx_data = 8'h12; rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    mem_a = 32'h1FFFF;
    tick();
    rst_in = 1'b1;
    tick();
    assertions++;
    if ({mem_rdata, io_buffer_full, tx_valid, program_stop, tx_overflow} !== 12'h000) begin
      failures++;
      $display("FAIL mid_reset_outputs: got rdata=%h ibf=%b txv=%b stop=%b ovf=%b required all 0",
               mem_rdata, io_buffer_full, tx_valid, program_stop, tx_overflow);
    end
    rst_in = 1'b0;
    mem_a = 32'h30000;
    tick();
    assertions++;
    if (mem_rdata !== 8'h00) begin
      failures++; $display("FAIL mid_reset_rx_empty: got %h required 00", mem_rdata);
    end
    mem_a = 32'h1FFFF;
    tick();
    assertions++;
    if (mem_rdata !== 8'h77) begin
      failures++; $display("FAIL ram_kept: got %h required 77", mem_rdata);
    end
    idle();
  endtask

  initial begin
    rst_in    = 1'b1;
    mem_a     = 32'h0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    tx_ready  = 1'b0;
    rx_data   = 8'h00;
    rx_valid  = 1'b0;
    test_reset();
    test_ram();
    test_tx_basic();
    test_tx_full();
    test_counter();
    test_rx();
    test_stop();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
